// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg -- shared definitions for the FIFO write arbiter.
//   arb_state_e : arbiter FSM state encoding (ARB_IDLE, ARB_GRANT)
//   id_width()  : width of a requester index, clog2(n) with a floor of 1
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if -- requester handshake plus FIFO write port.
//   req_valid  [NREQ]        per-requester word valid
//   req_data   [NREQ*WIDTH]  packed words, requester i at [i*WIDTH +: WIDTH]
//   req_ready  [NREQ]        per-requester accept (at most one high)
//   fifo_full                FIFO full flag
//   fifo_wr_en               FIFO write strobe
//   fifo_data  [WIDTH]       FIFO write data
// Modports: master = producers/FIFO side, slave = arbiter side.
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [WIDTH-1:0]      fifo_data;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_data
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_data
  );
endinterface

// File: rtl/fifo_arb_rr_pick.sv
// fifo_arb_rr_pick -- combinational round-robin selector.
//   req        [NREQ]  request vector
//   last_grant [ID_W]  index granted most recently
//   found              some request bit is set
//   idx        [ID_W]  first set request after last_grant, wrapping
module fifo_arb_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int ID_W = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last_grant,
  output logic            found,
  output logic [ID_W-1:0] idx
);

  // Two passes: indices above last_grant first, then wrap to 0..last_grant.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (ID_W'(i) > last_grant)) begin
        found = 1'b1;
        idx   = ID_W'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (ID_W'(i) <= last_grant)) begin
        found = 1'b1;
        idx   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter -- round-robin arbiter sharing one FIFO write port among
// NREQ requesters, one owner at a time for bursts of up to MAX_BURST words.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   bus (slave)        requester handshakes and FIFO write port
//   grant_id [ID_W]    current owner (valid while busy)
//   busy               a grant is active
//   word_cnt           per-requester saturating accepted-word counters,
//                      present only when FIFO_ARB_STATS_EN is defined
// Optional feature macro: FIFO_ARB_STATS_EN
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16,
  localparam int ID_W     = id_width(NREQ),
  localparam int BC_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fifo_wr_arbiter_if.slave      bus,
  output logic [ID_W-1:0]       grant_id,
  output logic                  busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0] word_cnt
`endif
);

  localparam logic [0:0] ST_IDLE  = ARB_IDLE;
  localparam logic [0:0] ST_GRANT = ARB_GRANT;

  if (NREQ < 2 || NREQ > 8) begin : g_chk_nreq
    $error("NREQ must be in 2..8");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_chk_burst
    $error("MAX_BURST must be in 1..255");
  end
  if (CNT_W < 1) begin : g_chk_cnt
    $error("CNT_W must be at least 1");
  end

  logic [0:0]       state;
  logic [ID_W-1:0]  last_grant;
  logic [BC_W-1:0]  burst_cnt;

  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic             owner_valid;
  logic [WIDTH-1:0] owner_data;
  logic             accept;
  logic             last_beat;

  fifo_arb_rr_pick #(.NREQ(NREQ)) u_pick (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  assign busy = (state == ST_GRANT);

  // Owner mux: valid and data of the requester held in grant_id.
  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == grant_id) begin
        owner_valid = bus.req_valid[i];
        owner_data  = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign accept    = busy && owner_valid && !bus.fifo_full;
  assign last_beat = (burst_cnt == BC_W'(MAX_BURST - 1));

  // fifo_full reaches ready/wr_en combinationally, so a full FIFO never
  // sees a write even in the cycle the flag rises.
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ready[i] = busy && !bus.fifo_full && (ID_W'(i) == grant_id);
    end
  end

  assign bus.fifo_wr_en = accept;
  assign bus.fifo_data  = busy ? owner_data : '0;

  // Control state: arbitration in IDLE, burst tracking in GRANT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant_id   <= '0;
      last_grant <= ID_W'(NREQ - 1);
      burst_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_id  <= pick_idx;
            burst_cnt <= '0;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Owner dropping valid ends the grant even while the FIFO is full.
          if (!owner_valid || (accept && last_beat)) begin
            state      <= ST_IDLE;
            last_grant <= grant_id;
          end else if (accept) begin
            burst_cnt <= burst_cnt + BC_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_stats
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[g] <= '0;
      end else if (accept && (grant_id == ID_W'(g)) && (cnt_q[g] != '1)) begin
        cnt_q[g] <= cnt_q[g] + CNT_W'(1);
      end
    end
    assign word_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule
